// File: rtl/ascon_serial_loader_pkg.sv
// Shared constants, state encoding and helper functions for the Ascon serial loader.
// Included by the loader top, its request interface and the PRNG lane.
package ascon_serial_loader_pkg;

    localparam int          ASCON_NONCE_W = 128;
    localparam int          RAND_LANES    = 9;
    localparam logic [31:0] LFSR_POLY     = 32'h80200003;
    localparam logic [31:0] LANE_GOLDEN   = 32'h9E3779B9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_START = 2'd2,
        ST_WAIT  = 2'd3
    } state_e;

    function automatic int max_of(int a, int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int calc_nb(int k, int l, int y);
        int m;
        m = max_of(max_of(k, ASCON_NONCE_W), max_of(l, y));
        return (m + 7) / 8;
    endfunction

    // An all-zero Galois LFSR would lock up, so such a seed becomes 1.
    function automatic logic [31:0] lane_seed(logic [31:0] seed, int lane);
        logic [31:0] s;
        s = seed ^ (32'(lane) * LANE_GOLDEN);
        return (s == 32'd0) ? 32'd1 : s;
    endfunction

    function automatic logic [31:0] lfsr_step(logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

endpackage

// File: rtl/ascon_serial_loader_if.sv
// Parallel request bus of the Ascon serial loader: one operand set plus op and a
// valid/ready handshake.
interface ascon_serial_loader_if
    import ascon_serial_loader_pkg::*;
#(
    parameter int K = 128,
    parameter int L = 40,
    parameter int Y = 96
);
    logic [K-1:0]             key_i;
    logic [ASCON_NONCE_W-1:0] nonce_i;
    logic [L-1:0]             ad_i;
    logic [Y-1:0]             pt_i;
    logic                     op_i;
    logic                     req_valid_i;
    logic                     req_ready_o;

    modport master (
        output key_i, nonce_i, ad_i, pt_i, op_i, req_valid_i,
        input  req_ready_o
    );

    modport slave (
        input  key_i, nonce_i, ad_i, pt_i, op_i, req_valid_i,
        output req_ready_o
    );
endinterface

// File: rtl/ascon_serial_loader_lfsr32.sv
// One 32-bit Galois LFSR lane (taps 32,22,2,1) of the masking-randomness generator.
// Free-runs every clock once reset is released.
module ascon_serial_loader_lfsr32
    import ascon_serial_loader_pkg::*;
#(
    parameter logic [31:0] SEED_LANE = 32'd1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] state_o
);
    logic [31:0] state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= SEED_LANE;
        else     state_q <= lfsr_step(state_q);
    end

    assign state_o = state_q;
endmodule

// File: rtl/ascon_serial_loader.sv
// Feeds one parallel Ascon request into the core a byte per cycle with fresh masking
// randomness, then pulses the selected start strobe and waits for the core's ready.
//
// state    | meaning
// IDLE     | request port open, data bytes and strobes low
// LOAD     | NB cycles, one operand byte per field per cycle
// START    | selected start strobe held high for START_CYC cycles
// WAIT     | hold until the matching core ready is sampled high
module ascon_serial_loader
    import ascon_serial_loader_pkg::*;
#(
    parameter int          K         = 128,
    parameter int          L         = 40,
    parameter int          Y         = 96,
    parameter int          START_CYC = 5,
    parameter logic [31:0] SEED      = 32'hACE12024
) (
    input  logic                  clk,
    input  logic                  rst,
    ascon_serial_loader_if.slave  req,
    input  logic                  enc_ready_i,
    input  logic                  dec_ready_i,
    output logic [39:0]           keyxSO,
    output logic [39:0]           noncexSO,
    output logic [39:0]           associated_dataxSO,
    output logic [39:0]           plain_textxSO,
    output logic [111:0]          r_64xSO,
    output logic [23:0]           r_128xSO,
    output logic [23:0]           r_ptxSO,
    output logic                  encryption_startxSO,
    output logic                  decryption_startxSO,
    output logic                  busy_o
);
    localparam int NB    = calc_nb(K, L, Y);
    localparam int SR_W  = NB * 8;
    localparam int CNT_W = $clog2(max_of(NB, START_CYC) + 1);

    function automatic logic [SR_W-1:0] msb_align(logic [SR_W-1:0] f, int w);
        return f << (SR_W - w);
    endfunction

    state_e            state_q;
    logic              op_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [SR_W-1:0]   sr_key_q, sr_non_q, sr_ad_q, sr_pt_q;
    logic [7:0]        key_byte_q, non_byte_q, ad_byte_q, pt_byte_q;
    logic              enc_start_q, dec_start_q;
    logic [SR_W-1:0]   key_al, non_al, ad_al, pt_al;

    assign key_al = msb_align(SR_W'(req.key_i), K);
    assign non_al = msb_align(SR_W'(req.nonce_i), ASCON_NONCE_W);
    assign ad_al  = msb_align(SR_W'(req.ad_i), L);
    assign pt_al  = msb_align(SR_W'(req.pt_i), Y);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= 1'b0;
            cnt_q       <= '0;
            sr_key_q    <= '0;
            sr_non_q    <= '0;
            sr_ad_q     <= '0;
            sr_pt_q     <= '0;
            key_byte_q  <= '0;
            non_byte_q  <= '0;
            ad_byte_q   <= '0;
            pt_byte_q   <= '0;
            enc_start_q <= 1'b0;
            dec_start_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req.req_valid_i) begin
                        op_q       <= req.op_i;
                        key_byte_q <= key_al[SR_W-1 -: 8];
                        non_byte_q <= non_al[SR_W-1 -: 8];
                        ad_byte_q  <= ad_al[SR_W-1 -: 8];
                        pt_byte_q  <= pt_al[SR_W-1 -: 8];
                        sr_key_q   <= key_al << 8;
                        sr_non_q   <= non_al << 8;
                        sr_ad_q    <= ad_al << 8;
                        sr_pt_q    <= pt_al << 8;
                        cnt_q      <= CNT_W'(NB - 1);
                        state_q    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (cnt_q == '0) begin
                        key_byte_q  <= '0;
                        non_byte_q  <= '0;
                        ad_byte_q   <= '0;
                        pt_byte_q   <= '0;
                        enc_start_q <= ~op_q;
                        dec_start_q <= op_q;
                        cnt_q       <= CNT_W'(START_CYC - 1);
                        state_q     <= ST_START;
                    end else begin
                        key_byte_q <= sr_key_q[SR_W-1 -: 8];
                        non_byte_q <= sr_non_q[SR_W-1 -: 8];
                        ad_byte_q  <= sr_ad_q[SR_W-1 -: 8];
                        pt_byte_q  <= sr_pt_q[SR_W-1 -: 8];
                        sr_key_q   <= sr_key_q << 8;
                        sr_non_q   <= sr_non_q << 8;
                        sr_ad_q    <= sr_ad_q << 8;
                        sr_pt_q    <= sr_pt_q << 8;
                        cnt_q      <= cnt_q - 1'b1;
                    end
                end
                ST_START: begin
                    if (cnt_q == '0) begin
                        enc_start_q <= 1'b0;
                        dec_start_q <= 1'b0;
                        state_q     <= ST_WAIT;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (op_q ? dec_ready_i : enc_ready_i) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Lane i drives bits [32i+31:32i]; everything random reads zero during reset.
    logic [RAND_LANES*32-1:0] rand_w, rand_g;

    for (genvar i = 0; i < RAND_LANES; i++) begin : g_lane
        ascon_serial_loader_lfsr32 #(.SEED_LANE(lane_seed(SEED, i))) u_lfsr (
            .clk     (clk),
            .rst     (rst),
            .state_o (rand_w[32*i +: 32])
        );
    end

    assign rand_g = rst ? '0 : rand_w;

    assign noncexSO            = {rand_g[31:0],   non_byte_q};
    assign plain_textxSO       = {rand_g[63:32],  pt_byte_q};
    assign associated_dataxSO  = {rand_g[95:64],  ad_byte_q};
    assign keyxSO              = {rand_g[127:96], key_byte_q};
    assign r_64xSO             = rand_g[239:128];
    assign r_ptxSO             = rand_g[263:240];
    assign r_128xSO            = rand_g[287:264];

    assign encryption_startxSO = enc_start_q;
    assign decryption_startxSO = dec_start_q;
    assign busy_o              = (state_q != ST_IDLE);
    assign req.req_ready_o     = (state_q == ST_IDLE) && !rst;
endmodule

// File: tb/tb_ascon_serial_loader.sv
// Self-checking bench for ascon_serial_loader: directed vectors plus randomized requests
// compared against a byte-slicing model and an LFSR sequence model.
module tb_ascon_serial_loader;
    localparam int          K         = 128;
    localparam int          L         = 40;
    localparam int          Y         = 96;
    localparam int          START_CYC = 5;
    localparam logic [31:0] SEED      = 32'hACE12024;
    localparam int          NB        = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enc_rdy = 1'b0;
    logic dec_rdy = 1'b0;
    logic [39:0]  keyxSO, noncexSO, associated_dataxSO, plain_textxSO;
    logic [111:0] r_64xSO;
    logic [23:0]  r_128xSO, r_ptxSO;
    logic         enc_st, dec_st, busy;
    int n_pass = 0;
    int n_total = 0;

    ascon_serial_loader_if #(.K(K), .L(L), .Y(Y)) rif ();

    ascon_serial_loader #(.K(K), .L(L), .Y(Y), .START_CYC(START_CYC), .SEED(SEED)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .req                 (rif),
        .enc_ready_i         (enc_rdy),
        .dec_ready_i         (dec_rdy),
        .keyxSO              (keyxSO),
        .noncexSO            (noncexSO),
        .associated_dataxSO  (associated_dataxSO),
        .plain_textxSO       (plain_textxSO),
        .r_64xSO             (r_64xSO),
        .r_128xSO            (r_128xSO),
        .r_ptxSO             (r_ptxSO),
        .encryption_startxSO (enc_st),
        .decryption_startxSO (dec_st),
        .busy_o              (busy)
    );

    always #5 clk = ~clk;

    wire [31:0]  byte_obs = {keyxSO[7:0], noncexSO[7:0], associated_dataxSO[7:0], plain_textxSO[7:0]};
    wire [287:0] rnd_obs  = {r_128xSO, r_ptxSO, r_64xSO, keyxSO[39:8], associated_dataxSO[39:8],
                             plain_textxSO[39:8], noncexSO[39:8]};
    wire [3:0]   ctl_obs  = {busy, rif.req_ready_o, enc_st, dec_st};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Byte n of a W-bit field: MSB-first, zero-filled past the end of the field.
    function automatic logic [7:0] ref_byte(logic [127:0] f, int w, int n);
        logic [7:0] b;
        b = '0;
        for (int j = 0; j < 8; j++) begin
            int idx;
            idx = w - 1 - 8 * n - j;
            if (idx >= 0) b[7-j] = f[idx];
        end
        return b;
    endfunction

    function automatic logic [31:0] ref_step(logic [31:0] s);
        logic lsb;
        lsb = s[0];
        s = s >> 1;
        if (lsb) s = s ^ 32'h80200003;
        return s;
    endfunction

    function automatic logic [31:0] ref_seed(int lane);
        logic [31:0] s;
        s = SEED ^ (32'(lane) * 32'h9E3779B9);
        if (s == 32'd0) s = 32'd1;
        return s;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        rif.req_valid_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_total++; if (ctl_obs !== 4'b0000) $display("FAIL reset_ctl cyc %0d got %b exp 0000", c, ctl_obs); else n_pass++;
            n_total++; if ({byte_obs, rnd_obs} !== '0) $display("FAIL reset_outputs cyc %0d got bytes %h rand %h exp 0", c, byte_obs, rnd_obs); else n_pass++;
        end
        rst = 1'b0;
        #1;
        n_total++; if (ctl_obs !== 4'b0100) $display("FAIL reset_release_ctl got %b exp 0100", ctl_obs); else n_pass++;
        tick();
        n_total++; if (ctl_obs !== 4'b0100) $display("FAIL idle_ctl got %b exp 0100", ctl_obs); else n_pass++;
    endtask

    task automatic accept_and_load(input string tag, input logic [127:0] k, input logic [127:0] nn,
                                   input logic [39:0] a, input logic [95:0] p, input logic op, input int stop_at);
        logic [31:0] exp_b;
        rif.key_i = k; rif.nonce_i = nn; rif.ad_i = a; rif.pt_i = p; rif.op_i = op;
        rif.req_valid_i = 1'b1;
        n_total++; if (rif.req_ready_o !== 1'b1) $display("FAIL %s accept_ready got %b exp 1", tag, rif.req_ready_o); else n_pass++;
        tick();
        rif.req_valid_i = $urandom_range(0, 1) == 1;
        rif.key_i = rnd128(); rif.nonce_i = rnd128(); rif.ad_i = 40'(rnd128()); rif.pt_i = 96'(rnd128()); rif.op_i = ~op;
        for (int n = 0; n < NB; n++) begin
            exp_b = {ref_byte(k, K, n), ref_byte(nn, 128, n), ref_byte({88'd0, a}, L, n), ref_byte({32'd0, p}, Y, n)};
            n_total++; if (byte_obs !== exp_b) $display("FAIL %s load_byte %0d got %h exp %h", tag, n, byte_obs, exp_b); else n_pass++;
            n_total++; if (ctl_obs !== 4'b1000) $display("FAIL %s load_ctl %0d got %b exp 1000", tag, n, ctl_obs); else n_pass++;
            if (n == stop_at) return;
            tick();
        end
    endtask

    task automatic run_op(input string tag, input logic [127:0] k, input logic [127:0] nn, input logic [39:0] a,
                          input logic [95:0] p, input logic op, input bit early, input int wait_cyc);
        logic [3:0] exp_c;
        accept_and_load(tag, k, nn, a, p, op, -1);
        if (early) begin
            if (op) dec_rdy = 1'b1; else enc_rdy = 1'b1;
        end
        exp_c = op ? 4'b1001 : 4'b1010;
        for (int i = 0; i < START_CYC; i++) begin
            n_total++; if (ctl_obs !== exp_c) $display("FAIL %s strobe_ctl %0d got %b exp %b", tag, i, ctl_obs, exp_c); else n_pass++;
            n_total++; if (byte_obs !== 32'd0) $display("FAIL %s start_bytes %0d got %h exp 0", tag, i, byte_obs); else n_pass++;
            tick();
        end
        n_total++; if (ctl_obs !== 4'b1000) $display("FAIL %s wait_entry_ctl got %b exp 1000", tag, ctl_obs); else n_pass++;
        if (!early) begin
            for (int i = 0; i < wait_cyc; i++) begin
                if (op) enc_rdy = 1'b1; else dec_rdy = 1'b1;
                tick();
                n_total++; if (ctl_obs !== 4'b1000) $display("FAIL %s wait_hold %0d got %b exp 1000", tag, i, ctl_obs); else n_pass++;
            end
            enc_rdy = !op;
            dec_rdy = op;
        end
        rif.req_valid_i = 1'b0;
        tick();
        enc_rdy = 1'b0;
        dec_rdy = 1'b0;
        n_total++; if (ctl_obs !== 4'b0100) $display("FAIL %s release_ctl got %b exp 0100", tag, ctl_obs); else n_pass++;
    endtask

    task automatic test_load_and_strobe();
        run_op("enc_vec", 128'h5362006eff0b33bc8bb9950abdb242fc, 128'h1ccfafbc6dc738283ca9fe21ce0fccaa,
               40'h4153434f4e, 96'h48656c6c6f20576f726c6421, 1'b0, 1'b0, 3);
    endtask

    task automatic test_decrypt();
        run_op("dec_vec", rnd128(), rnd128(), 40'(rnd128()), 96'(rnd128()), 1'b1, 1'b0, 4);
    endtask

    task automatic test_mid_reset();
        accept_and_load("midload", rnd128(), rnd128(), 40'(rnd128()), 96'(rnd128()), 1'b0, 7);
        #2 rst = 1'b1;
        #1;
        n_total++; if (ctl_obs !== 4'b0000) $display("FAIL midload_async_ctl got %b exp 0000", ctl_obs); else n_pass++;
        n_total++; if ({byte_obs, rnd_obs} !== '0) $display("FAIL midload_async_out got bytes %h rand %h exp 0", byte_obs, rnd_obs); else n_pass++;
        tick();
        rst = 1'b0;
        rif.req_valid_i = 1'b0;
        #1;
        accept_and_load("midstart", rnd128(), rnd128(), 40'(rnd128()), 96'(rnd128()), 1'b1, -1);
        tick();
        n_total++; if (ctl_obs !== 4'b1001) $display("FAIL midstart_strobe got %b exp 1001", ctl_obs); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++; if (ctl_obs !== 4'b0000) $display("FAIL midstart_async_ctl got %b exp 0000", ctl_obs); else n_pass++;
        tick();
        rst = 1'b0;
        rif.req_valid_i = 1'b0;
        #1;
        run_op("after_reset", rnd128(), rnd128(), 40'(rnd128()), 96'(rnd128()), 1'b0, 1'b0, 1);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 6; r++) begin
            run_op($sformatf("rand%0d", r), rnd128(), rnd128(), 40'(rnd128()), 96'(rnd128()),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end
    endtask

    task automatic test_prng();
        logic [31:0]  lane [9];
        logic [287:0] hist [64];
        logic [287:0] exp_r, prev;
        int n_zero, n_same;
        n_zero = 0;
        n_same = 0;
        prev = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 9; i++) lane[i] = ref_seed(i);
        for (int c = 0; c < 1000; c++) begin
            for (int i = 0; i < 9; i++) exp_r[32*i +: 32] = lane[i];
            n_total++; if (rnd_obs !== exp_r) $display("FAIL prng_seq cyc %0d got %h exp %h", c, rnd_obs, exp_r); else n_pass++;
            if (rnd_obs == '0) n_zero++;
            if (c > 0 && rnd_obs == prev) n_same++;
            if (c < 64) hist[c] = rnd_obs;
            prev = rnd_obs;
            for (int i = 0; i < 9; i++) lane[i] = ref_step(lane[i]);
            tick();
        end
        n_total++; if (n_zero !== 0) $display("FAIL prng_nonzero got %0d zero cycles exp 0", n_zero); else n_pass++;
        n_total++; if (n_same !== 0) $display("FAIL prng_changes got %0d repeated cycles exp 0", n_same); else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        for (int c = 0; c < 64; c++) begin
            n_total++; if (rnd_obs !== hist[c]) $display("FAIL prng_repeat cyc %0d got %h exp %h", c, rnd_obs, hist[c]); else n_pass++;
            tick();
        end
    endtask

    initial begin
        rif.key_i = '0; rif.nonce_i = '0; rif.ad_i = '0; rif.pt_i = '0;
        rif.op_i = 1'b0; rif.req_valid_i = 1'b0;
        test_reset();
        test_load_and_strobe();
        test_decrypt();
        test_mid_reset();
        test_back_to_back();
        test_prng();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
